// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and stream constants for imem_loader
package loader_pkg;
    typedef enum logic [2:0] {LEN, DATA, CSUM, DONE, ERR} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W = 32;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake, instruction-memory write port and status of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              core_rst;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;
    modport slave (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata, core_rst, done, err, words_loaded
    );
    modport master (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata, core_rst, done, err, words_loaded
    );
endinterface

// File: rtl/byte_assembler.sv
// byte_assembler: little-endian 8-to-32 shift assembler; word_valid pulses the cycle after the 4th byte
module byte_assembler
    import loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic [7:0]                  data,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        last,
    output logic                        word_valid
);
    logic [1:0] idx;
    assign last = idx == 2'(BYTES_PER_WORD - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            word <= '0;
            word_valid <= 1'b0;
        end else if (clr) begin
            idx <= '0;
            word <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= en && last;
            if (en) begin
                word <= {data, word[8*BYTES_PER_WORD-1:8]};
                idx <= idx + 2'd1;
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader writing a length-prefixed byte stream into imem; define LOADER_CHECKSUM_EN for a trailing XOR checksum byte
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(1) << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN = CSUM;
    logic [7:0] csum;
`else
    localparam state_t FIN = DONE;
`endif
    state_t st, nxt;
    logic run, acc, cnt_last, cnt_valid, dat_last, dat_valid, last_word;
    logic [CNT_W-1:0] cnt_word, n_in, n;
    logic [31:0] dat_word;
    logic [ADDR_W:0] loaded;
    logic [ADDR_W-1:0] waddr;
    assign acc = bus.in_valid && bus.in_ready;
    // full count as it lands, so the LEN decision happens on the accepting edge
    assign n_in = {bus.in_data, cnt_word[CNT_W-1:8]};
    assign last_word = CNT_W'(loaded) + CNT_W'(1) == n;
    byte_assembler u_cnt (
        .clk(clk), .rst(rst), .clr(st != LEN), .en(acc && st == LEN), .data(bus.in_data),
        .word(cnt_word), .last(cnt_last), .word_valid(cnt_valid)
    );
    byte_assembler u_dat (
        .clk(clk), .rst(rst), .clr(st != DATA), .en(acc && st == DATA), .data(bus.in_data),
        .word(dat_word), .last(dat_last), .word_valid(dat_valid)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= LEN;
        else st <= nxt;
    end
    always_comb begin
        nxt = st;
        case (st)
            LEN:  if (acc && cnt_last) nxt = n_in == '0 ? FIN : n_in > CAP ? ERR : DATA;
            DATA: if (acc && dat_last && last_word) nxt = FIN;
`ifdef LOADER_CHECKSUM_EN
            CSUM: if (acc) nxt = bus.in_data == csum ? DONE : ERR;
`endif
            default: nxt = st;
        endcase
    end
    always_comb begin
        bus.in_ready = run && (st == LEN || st == DATA || st == CSUM);
        bus.done = st == DONE;
        bus.err = st == ERR;
        bus.core_rst = st != DONE;
    end
    // the count assembler is cleared once LEN is left, so latch N while it is still valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
            n <= '0;
            loaded <= '0;
            waddr <= '0;
        end else begin
            run <= 1'b1;
            if (cnt_valid) n <= cnt_word;
            if (acc && st == DATA && dat_last) begin
                loaded <= loaded + 1'b1;
                waddr <= loaded[ADDR_W-1:0];
            end
        end
    end
`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum <= '0;
        else if (acc && st == DATA) csum <= csum ^ bus.in_data;
    end
`endif
    assign bus.we = dat_valid;
    assign bus.wdata = dat_word;
    assign bus.waddr = waddr;
    assign bus.words_loaded = loaded;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; honours LOADER_CHECKSUM_EN
module tb_imem_loader;
    localparam int ADDR_W = 10;
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    imem_loader_if #(.ADDR_W(ADDR_W)) bif ();
    imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bif));
    always #5 clk = ~clk;

    wr_t sb[$];
    int we_cyc[$];
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] csum = 8'h00;
    logic [ADDR_W-1:0] next_addr = '0;

    always @(posedge clk) cyc++;

    // every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && bif.we) begin
            wr_t exp;
            vectors++;
            we_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got addr %0d data %h, no write expected", bif.waddr, bif.wdata);
            end else begin
                exp = sb.pop_front();
                if ({bif.waddr, bif.wdata} !== exp) begin
                    miscompares++;
                    $display("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                             bif.waddr, bif.wdata, exp.a, exp.d);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        if (gap > 0) begin
            repeat ($urandom_range(0, gap)) @(posedge clk);
            #1;
        end
        bif.in_valid = 1'b1;
        bif.in_data = b;
        @(negedge clk);
        while (!bif.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bif.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: in_ready=%b, required 1", bif.in_ready);
        end else @(posedge clk);
        #1 bif.in_valid = 1'b0;
    endtask

    task automatic send_count(input logic [31:0] n, input int gap);
        for (int i = 0; i < 4; i++) send(n[8*i +: 8], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        sb.push_back({next_addr, w});
        next_addr++;
        for (int i = 0; i < 4; i++) begin
            send(w[8*i +: 8], gap);
            csum ^= w[8*i +: 8];
        end
    endtask

    task automatic send_tail();
`ifdef LOADER_CHECKSUM_EN
        send(csum, 0);
`endif
    endtask

    // the junk byte offered on the release edge must not be consumed
    task automatic do_reset();
        bif.in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        we_cyc.delete();
        csum = 8'h00;
        next_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bif.in_valid = 1'b1;
        bif.in_data = 8'hFF;
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.in_valid = 1'b0;
        bif.in_data = 8'h00;
        @(negedge clk);
        vectors++;
        if (bif.in_ready !== 1'b0 || bif.we !== 1'b0 || bif.waddr !== '0 || bif.wdata !== 32'h0 ||
            bif.words_loaded !== '0 || bif.done !== 1'b0 || bif.err !== 1'b0 || bif.core_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_values: ready=%b we=%b waddr=%0d wdata=%h wl=%0d done=%b err=%b core_rst=%b, required 0 0 0 0 0 0 0 1",
                     bif.in_ready, bif.we, bif.waddr, bif.wdata, bif.words_loaded, bif.done, bif.err, bif.core_rst);
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if (bif.in_ready !== 1'b1 || bif.core_rst !== 1'b1 || bif.done !== 1'b0) begin
            miscompares++;
            $display("FAIL after_release: ready=%b core_rst=%b done=%b, required 1 1 0", bif.in_ready, bif.core_rst, bif.done);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_count(32'd2, 0);
        send_word(32'h00000513, 0);
        send_word(32'h00100593, 0);
        send_tail();
        @(negedge clk);
        vectors++;
        if (bif.done !== 1'b1 || bif.core_rst !== 1'b0 || bif.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: done=%b core_rst=%b ready=%b, required 1 0 0", bif.done, bif.core_rst, bif.in_ready);
        end
        @(negedge clk);
        vectors++;
        if (we_cyc.size() != 2 || we_cyc[1] - we_cyc[0] != 4) begin
            miscompares++;
            $display("FAIL b2b_we_spacing: %0d pulses, required 2 pulses 4 cycles apart", we_cyc.size());
        end
        vectors++;
        if (bif.words_loaded !== 11'd2 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: words_loaded=%0d pending=%0d, required 2 and 0", bif.words_loaded, sb.size());
        end
    endtask

    task automatic test_zero();
        do_reset();
        send_count(32'd0, 0);
        send_tail();
        @(negedge clk);
        vectors++;
        if (bif.done !== 1'b1 || bif.err !== 1'b0 || bif.core_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: done=%b err=%b core_rst=%b, required 1 0 0", bif.done, bif.err, bif.core_rst);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (we_cyc.size() != 0 || bif.words_loaded !== '0) begin
            miscompares++;
            $display("FAIL zero_writes: pulses=%0d wl=%0d, required 0 0", we_cyc.size(), bif.words_loaded);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_count(32'h0000_0401, 0);
        @(negedge clk);
        vectors++;
        if (bif.err !== 1'b1 || bif.in_ready !== 1'b0 || bif.core_rst !== 1'b1 || bif.done !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_err: err=%b ready=%b core_rst=%b done=%b, required 1 0 1 0",
                     bif.err, bif.in_ready, bif.core_rst, bif.done);
        end
        bif.in_valid = 1'b1;
        bif.in_data = 8'h00;
        repeat (3) @(negedge clk);
        bif.in_valid = 1'b0;
        vectors++;
        if (bif.err !== 1'b1 || bif.words_loaded !== '0 || we_cyc.size() != 0) begin
            miscompares++;
            $display("FAIL overflow_sticky: err=%b wl=%0d pulses=%0d, required 1 0 0", bif.err, bif.words_loaded, we_cyc.size());
        end
    endtask

    task automatic test_max();
        do_reset();
        send_count(32'd1 << ADDR_W, 0);
        for (int i = 0; i < (1 << ADDR_W); i++) send_word($urandom, 0);
        send_tail();
        @(negedge clk);
        vectors++;
        if (bif.done !== 1'b1 || bif.err !== 1'b0 || bif.words_loaded !== 11'd1024) begin
            miscompares++;
            $display("FAIL max_image: done=%b err=%b wl=%0d, required 1 0 1024", bif.done, bif.err, bif.words_loaded);
        end
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL max_pending: %0d writes missing, required 0", sb.size());
        end
    endtask

    task automatic test_random_valid();
        do_reset();
        send_count(32'd3, 3);
        send_word(32'h00000513, 3);
        vectors++;
        if (bif.done !== 1'b0 || bif.core_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL rand_midload: done=%b core_rst=%b, required 0 1", bif.done, bif.core_rst);
        end
        send_word(32'h00100593, 3);
        send_word(32'hDEADBEEF, 3);
        send_tail();
        repeat (2) @(negedge clk);
        vectors++;
        if (bif.done !== 1'b1 || bif.words_loaded !== 11'd3 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL rand_end: done=%b wl=%0d pending=%0d, required 1 3 0", bif.done, bif.words_loaded, sb.size());
        end
    endtask

    task automatic test_abort();
        do_reset();
        send_count(32'd2, 0);
        send_word(32'h0BADF00D, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        rst = 1'b1;
        #1;
        vectors++;
        if (bif.in_ready !== 1'b0 || bif.we !== 1'b0 || bif.words_loaded !== '0 || bif.core_rst !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL abort_reset: ready=%b we=%b wl=%0d core_rst=%b pending=%0d, required 0 0 0 1 0",
                     bif.in_ready, bif.we, bif.words_loaded, bif.core_rst, sb.size());
        end
        do_reset();
        send_count(32'd1, 0);
        send_word(32'hCAFEF00D, 0);
        send_tail();
        repeat (2) @(negedge clk);
        vectors++;
        if (bif.done !== 1'b1 || bif.words_loaded !== 11'd1 || sb.size() != 0 || we_cyc.size() != 1) begin
            miscompares++;
            $display("FAIL abort_reload: done=%b wl=%0d pending=%0d pulses=%0d, required 1 1 0 1",
                     bif.done, bif.words_loaded, sb.size(), we_cyc.size());
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            send_count(32'd1, 0);
            send_word(32'h11223344, 0);
            send(k == 0 ? 8'h44 : 8'h45, 0);
            repeat (2) @(negedge clk);
            vectors++;
            if (bif.done !== (k == 0) || bif.err !== (k != 0) || we_cyc.size() != 1) begin
                miscompares++;
                $display("FAIL checksum_%0d: done=%b err=%b pulses=%0d, required %b %b 1",
                         k, bif.done, bif.err, we_cyc.size(), k == 0, k != 0);
            end
        end
    endtask
`endif

    initial begin
        bif.in_valid = 1'b0;
        bif.in_data = 8'h00;
        test_reset();
        test_back_to_back();
        test_zero();
        test_overflow();
        test_max();
        test_random_valid();
        test_abort();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
